// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the C0 fetch/decode stage: instruction field layout,
// class codes, sequencer states and the decoded control bundle.
package fetch_decode_pkg;

   localparam int ADDR_W = 8;
   localparam int INST_W = 26;
   localparam int RET_W  = 16;

   localparam int CLS_LSB = 24;
   localparam int MS_LSB  = 22;
   localparam int IRS_POS = 21;
   localparam int RS_LSB  = 18;
   localparam int AR_LSB  = 15;
   localparam int BS_LSB  = 12;
   localparam int OP_LSB  = 8;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      CLS_NOP = 2'b00,
      CLS_ALU = 2'b01,
      CLS_JMP = 2'b10,
      CLS_MEM = 2'b11
   } cls_e;

   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_EXEC1   = 3'd1,
      ST_EXEC2   = 3'd2,
      ST_HALTED  = 3'd3,
      ST_FAULTED = 3'd4
   } state_e;

   typedef struct packed {
      cls_e       cls;
      logic       hlt;
      logic [1:0] ms;
      logic       irs;
      logic [2:0] rs;
      logic [2:0] ar;
      logic [2:0] bs;
      logic [3:0] op;
      logic [7:0] imm;
   } ctrl_t;

   function automatic logic is_hlt(input logic [INST_W-1:0] w);
      return (cls_e'(w[CLS_LSB +: 2]) == CLS_NOP) && (w[OP_LSB +: 4] == OP_HLT);
   endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// ROM fetch port: the stage drives address/request, the ROM answers with ack/data.
// The request is held until acknowledged; data is only meaningful on the ack cycle.
interface fetch_decode_if;
   import fetch_decode_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic              rom_req;
   logic              rom_ack;
   logic [INST_W-1:0] rom_data;

   modport master (
      output rom_addr,
      output rom_req,
      input  rom_ack,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      input  rom_req,
      output rom_ack,
      output rom_data
   );

endinterface

// File: rtl/fetch_decode_field_decode.sv
// Purely combinational split of an instruction word into class, HLT flag and select fields.
// Zero latency; no class gating here, the sequencer decides when the class strobes are live.
module fetch_decode_field_decode
   import fetch_decode_pkg::*;
(
   input  logic [INST_W-1:0] i_ir,
   output ctrl_t             o_ctrl
);

   always_comb begin
      o_ctrl     = '0;
      o_ctrl.cls = cls_e'(i_ir[CLS_LSB +: 2]);
      o_ctrl.hlt = is_hlt(i_ir);
      o_ctrl.ms  = i_ir[MS_LSB +: 2];
      o_ctrl.irs = i_ir[IRS_POS];
      o_ctrl.rs  = i_ir[RS_LSB +: 3];
      o_ctrl.ar  = i_ir[AR_LSB +: 3];
      o_ctrl.bs  = i_ir[BS_LSB +: 3];
      o_ctrl.op  = i_ir[OP_LSB +: 4];
      o_ctrl.imm = i_ir[IMM_LSB +: 8];
   end

endmodule

// File: rtl/fetch_decode.sv
// C0 fetch/decode sequencer: FETCH (waits on ROM ack, bounded) -> EXEC1 (CLK1) -> EXEC2 (CLK2),
// at least 3 cycles per instruction; HLT or an ack timeout parks the core until reset.
module fetch_decode
   import fetch_decode_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_addr,
   fetch_decode_if.master    io_rom,
   output logic              o_mem_inst,
   output logic              o_alu_inst,
   output logic              o_jmp_inst,
   output logic              o_ms1,
   output logic              o_ms0,
   output logic              o_irs,
   output logic [2:0]        o_rs,
   output logic [2:0]        o_ar,
   output logic [2:0]        o_bs,
   output logic [3:0]        o_op,
   output logic [7:0]        o_imm,
   output logic              o_clk1,
   output logic              o_clk2,
   output logic              o_halt,
   output logic              o_fault,
   output logic [RET_W-1:0]  o_retired
);

   localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_e             r_state;
   state_e             w_next;
   logic [INST_W-1:0]  r_ir;
   logic [CNT_W-1:0]   r_cnt;
   logic [RET_W-1:0]   r_retired;
   logic               r_clk1;
   logic               r_clk2;
   ctrl_t              w_ctrl;
   logic               w_ack;
   logic               w_req;
   logic               w_exec;
   logic               w_halt;
   logic               w_fault;

   assign w_ack = io_rom.rom_ack;

   fetch_decode_field_decode u_field_decode (
      .i_ir   (r_ir),
      .o_ctrl (w_ctrl)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (w_ack) begin
               w_next = ST_EXEC1;
            end else if (r_cnt == CNT_LAST) begin
               w_next = ST_FAULTED;
            end
         end
         ST_EXEC1:   w_next = w_ctrl.hlt ? ST_HALTED : ST_EXEC2;
         ST_EXEC2:   w_next = ST_FETCH;
         ST_HALTED:  w_next = ST_HALTED;
         ST_FAULTED: w_next = ST_FAULTED;
         default:    w_next = ST_FETCH;
      endcase
   end

   // Request is masked by reset directly so nothing reaches the ROM while reset is held.
   always_comb begin
      w_req   = 1'b0;
      w_exec  = 1'b0;
      w_halt  = 1'b0;
      w_fault = 1'b0;
      case (r_state)
         ST_FETCH:           w_req = !i_rst;
         ST_EXEC1, ST_EXEC2: w_exec = 1'b1;
         ST_HALTED:          w_halt = 1'b1;
         ST_FAULTED: begin
            w_halt  = 1'b1;
            w_fault = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are registered from the next state so each is a clean, single-cycle pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ir      <= '0;
         r_cnt     <= '0;
         r_retired <= '0;
         r_clk1    <= 1'b0;
         r_clk2    <= 1'b0;
      end else begin
         r_clk1 <= (w_next == ST_EXEC1);
         r_clk2 <= (w_next == ST_EXEC2);
         if (r_state == ST_FETCH) begin
            if (w_ack) begin
               r_ir  <= io_rom.rom_data;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if ((r_state == ST_EXEC2) || ((r_state == ST_EXEC1) && w_ctrl.hlt)) begin
            r_retired <= r_retired + RET_W'(1);
         end
      end
   end

   assign io_rom.rom_req  = w_req;
   assign io_rom.rom_addr = w_req ? i_addr : '0;

   assign o_mem_inst = w_exec && (w_ctrl.cls == CLS_MEM);
   assign o_alu_inst = w_exec && (w_ctrl.cls == CLS_ALU);
   assign o_jmp_inst = w_exec && (w_ctrl.cls == CLS_JMP);
   assign o_ms1      = w_ctrl.ms[1];
   assign o_ms0      = w_ctrl.ms[0];
   assign o_irs      = w_ctrl.irs;
   assign o_rs       = w_ctrl.rs;
   assign o_ar       = w_ctrl.ar;
   assign o_bs       = w_ctrl.bs;
   assign o_op       = w_ctrl.op;
   assign o_imm      = w_ctrl.imm;
   assign o_clk1     = r_clk1;
   assign o_clk2     = r_clk2;
   assign o_halt     = w_halt;
   assign o_fault    = w_fault;
   assign o_retired  = r_retired;

endmodule
